scan_mux_nx1: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with a built-in channel sequencer. It generalises the gate-level 4x1 mux into a configurable width and depth block. It adds manual, free-running auto-scan, hold and single-sweep modes, a channel-enable mask and a dwell counter. It feeds time-multiplexed displays and serial samplers in the chapter 5/6 designs.

---
 rtl/scan_mux_nx1.sv | 245 ++++++++++++++++++++++++
 tb/tb_scan_mux_nx1.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux_nx1.sv
// scan_mux_nx1
// N-channel, WIDTH-bit registered multiplexer with a built-in channel
// sequencer. It supports manual select, free-running auto-scan, hold and
// single-sweep modes, with a channel-enable mask and a per-channel dwell time.
//
// Ports:
//   clock       rising-edge clock
//   reset_b     asynchronous active-low reset
//   mode        00 manual, 01 auto-scan, 10 hold, 11 single-sweep
//   sel_in      channel select used in manual mode
//   en_mask     bit i enables channel i for scan/sweep
//   start       one-cycle pulse that launches a sweep in mode 11
//   d           packed channels, channel i = d[i*WIDTH +: WIDTH]
//   y           registered selected data
//   sel_out     channel index currently driving y
//   valid       y holds legal selected data
//   sweep_done  one-cycle pulse at the end of a sweep
//   fsm_state   sweep FSM state (00 idle, 01 sweep, 10 done) for observation
//
// Handshake: there is no flow control. start is sampled on a rising edge only
// while mode is 11 and the sweep FSM is idle; sweep_done is high for exactly
// the one cycle the FSM spends in DONE (or the cycle after a start with an
// empty mask).
module scan_mux_nx1 #(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 1,
    parameter int  DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [N_CH-1:0]       en_mask,
    input  logic                  start,
    input  logic [N_CH*WIDTH-1:0] d,
    output logic [WIDTH-1:0]      y,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  valid,
    output logic                  sweep_done,
    output logic [1:0]            fsm_state
);

    localparam int               CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_SWEEP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SWEEP = 2'b01,
        S_DONE  = 2'b10
    } sweep_state_t;

    sweep_state_t     state, state_n;
    logic [CNT_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] y_n;
    logic [SEL_W-1:0] sel_n;
    logic             valid_n;
    logic             done_n;

    // Sequencer helpers
    logic             any_en;
    logic [SEL_W-1:0] low_idx;
    logic             above_found;
    logic [SEL_W-1:0] above_idx;
    logic             cur_en;
    logic             in_range;
    logic             entering_auto;
    logic             step_adv;
    logic [SEL_W-1:0] step_idx;

    // Channel extraction guarded against indices >= N_CH (possible when
    // N_CH is not a power of two); an illegal index reads as zero.
    function automatic logic [WIDTH-1:0] chan(input logic [SEL_W-1:0] idx,
                                              input logic [N_CH*WIDTH-1:0] dv);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(idx) == i) r = dv[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    assign fsm_state = state;

    // State register: every piece of state lives here.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            y          <= '0;
            sel_out    <= '0;
            valid      <= 1'b0;
            sweep_done <= 1'b0;
            dwell_cnt  <= '0;
            state      <= S_IDLE;
            mode_q     <= MODE_MANUAL;
        end else begin
            y          <= y_n;
            sel_out    <= sel_n;
            valid      <= valid_n;
            sweep_done <= done_n;
            dwell_cnt  <= dwell_cnt_n;
            state      <= state_n;
            mode_q     <= mode;
        end
    end

    // Enabled-channel search: lowest enabled index, and the lowest enabled
    // index strictly above the current one. Scanning downward lets the last
    // hit be the lowest match.
    always_comb begin
        any_en      = |en_mask;
        low_idx     = '0;
        above_found = 1'b0;
        above_idx   = '0;
        cur_en      = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                low_idx = SEL_W'(i);
                if (i > int'(sel_out)) begin
                    above_found = 1'b1;
                    above_idx   = SEL_W'(i);
                end
            end
            if (int'(sel_out) == i) cur_en = en_mask[i];
        end
        in_range      = (int'(sel_in) < N_CH);
        entering_auto = (mode == MODE_AUTO) && (mode_q != MODE_AUTO);
        // Leave the current channel when its dwell expires, or at once if
        // it is (or has become) disabled.
        step_adv      = !cur_en || (dwell_cnt == CNT_LAST);
        step_idx      = above_found ? above_idx : low_idx;
    end

    // Next-state and output logic.
    always_comb begin
        y_n         = y;
        sel_n       = sel_out;
        valid_n     = valid;
        done_n      = 1'b0;
        dwell_cnt_n = dwell_cnt;
        state_n     = S_IDLE;   // any mode other than 11 aborts a sweep

        case (mode)
            MODE_MANUAL: begin
                sel_n       = sel_in;
                dwell_cnt_n = '0;
                if (in_range) begin
                    y_n     = chan(sel_in, d);
                    valid_n = 1'b1;
                end else begin
                    y_n     = '0;
                    valid_n = 1'b0;
                end
            end

            MODE_AUTO: begin
                if (!any_en) begin
                    valid_n     = 1'b0;
                    dwell_cnt_n = '0;
                end else if (entering_auto && cur_en) begin
                    // Fresh dwell on the channel we arrived on.
                    dwell_cnt_n = '0;
                    y_n         = chan(sel_out, d);
                    valid_n     = 1'b1;
                end else if (step_adv) begin
                    sel_n       = step_idx;
                    dwell_cnt_n = '0;
                    y_n         = chan(step_idx, d);
                    valid_n     = 1'b1;
                end else begin
                    dwell_cnt_n = dwell_cnt + CNT_W'(1);
                    y_n         = chan(sel_out, d);
                    valid_n     = 1'b1;
                end
            end

            MODE_HOLD: begin
                // Everything frozen; defaults already hold.
            end

            MODE_SWEEP: begin
                case (state)
                    S_IDLE: begin
                        state_n = S_IDLE;
                        if (start) begin
                            if (any_en) begin
                                sel_n       = low_idx;
                                dwell_cnt_n = '0;
                                y_n         = chan(low_idx, d);
                                valid_n     = 1'b1;
                                state_n     = S_SWEEP;
                            end else begin
                                // Nothing to sweep: report completion at once.
                                done_n  = 1'b1;
                                valid_n = 1'b0;
                            end
                        end
                    end

                    S_SWEEP: begin
                        state_n = S_SWEEP;
                        if (!any_en) begin
                            valid_n = 1'b0;
                            done_n  = 1'b1;
                            state_n = S_DONE;
                        end else if (step_adv) begin
                            if (above_found) begin
                                sel_n       = above_idx;
                                dwell_cnt_n = '0;
                                y_n         = chan(above_idx, d);
                                valid_n     = 1'b1;
                            end else begin
                                // Last enabled channel finished: no wrap.
                                dwell_cnt_n = '0;
                                done_n      = 1'b1;
                                state_n     = S_DONE;
                            end
                        end else begin
                            dwell_cnt_n = dwell_cnt + CNT_W'(1);
                            y_n         = chan(sel_out, d);
                            valid_n     = 1'b1;
                        end
                    end

                    S_DONE: begin
                        state_n = S_IDLE;
                    end

                    default: begin
                        state_n = S_IDLE;
                    end
                endcase
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_scan_mux_nx1.sv
module tb_scan_mux_nx1;

    localparam logic [3:0] CA = 4'hA;
    localparam logic [3:0] CB = 4'hB;
    localparam logic [3:0] CC = 4'hC;
    localparam logic [3:0] CD = 4'hD;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_b;

    // DUT A: N_CH=4, WIDTH=4, DWELL=2
    logic [1:0]  mode;
    logic [1:0]  sel_in;
    logic [3:0]  en_mask;
    logic        start;
    logic [15:0] d;
    logic [3:0]  y;
    logic [1:0]  sel_out;
    logic        valid;
    logic        sweep_done;
    logic [1:0]  fsm_state;

    // DUT B: N_CH=3, WIDTH=4, DWELL=2 (manual mode, out-of-range select)
    logic [1:0]  mode_b;
    logic [1:0]  sel_in_b;
    logic [2:0]  en_mask_b;
    logic        start_b;
    logic [11:0] d_b;
    logic [3:0]  y_b;
    logic [1:0]  sel_out_b;
    logic        valid_b;
    logic        sweep_done_b;
    logic [1:0]  fsm_state_b;

    scan_mux_nx1 #(.N_CH(4), .WIDTH(4), .DWELL(2)) dut_a (
        .clock      (clock),
        .reset_b    (reset_b),
        .mode       (mode),
        .sel_in     (sel_in),
        .en_mask    (en_mask),
        .start      (start),
        .d          (d),
        .y          (y),
        .sel_out    (sel_out),
        .valid      (valid),
        .sweep_done (sweep_done),
        .fsm_state  (fsm_state)
    );

    scan_mux_nx1 #(.N_CH(3), .WIDTH(4), .DWELL(2)) dut_b (
        .clock      (clock),
        .reset_b    (reset_b),
        .mode       (mode_b),
        .sel_in     (sel_in_b),
        .en_mask    (en_mask_b),
        .start      (start_b),
        .d          (d_b),
        .y          (y_b),
        .sel_out    (sel_out_b),
        .valid      (valid_b),
        .sweep_done (sweep_done_b),
        .fsm_state  (fsm_state_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];   // {valid, sweep_done, sel_out[1:0], y[3:0]} for DUT A
    logic [6:0] exp_b[$];   // {valid, sel_out[1:0], y[3:0]} for DUT B

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic sd, input logic [1:0] s, input logic [3:0] yv);
        exp_q.push_back({v, sd, s, yv});
    endtask

    task automatic push_b(input logic v, input logic [1:0] s, input logic [3:0] yv);
        exp_b.push_back({v, s, yv});
    endtask

    // Advance one clock, then compare DUT outputs with the oldest expectation.
    task automatic tick(input string tag);
        logic [7:0] e;
        logic [6:0] eb;
        @(posedge clock);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".y"},          8'(y),          8'(e[3:0]));
            chk({tag, ".sel_out"},    8'(sel_out),    8'(e[5:4]));
            chk({tag, ".sweep_done"}, 8'(sweep_done), 8'(e[6]));
            chk({tag, ".valid"},      8'(valid),      8'(e[7]));
        end
        if (exp_b.size() != 0) begin
            eb = exp_b.pop_front();
            chk({tag, ".b.y"},       8'(y_b),       8'(eb[3:0]));
            chk({tag, ".b.sel_out"}, 8'(sel_out_b), 8'(eb[5:4]));
            chk({tag, ".b.valid"},   8'(valid_b),   8'(eb[6]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] scan_seq [8];
        logic [3:0] scan_y   [8];
        scan_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
        scan_y   = '{CA, CA, CB, CB, CD, CD, CA, CA};

        reset_b   = 1'b0;
        mode      = 2'b00;
        sel_in    = 2'd0;
        en_mask   = 4'b0000;
        start     = 1'b0;
        d         = 16'hDCBA;
        mode_b    = 2'b00;
        sel_in_b  = 2'd0;
        en_mask_b = 3'b111;
        start_b   = 1'b0;
        d_b       = 12'hCBA;

        // Reset state
        @(posedge clock);
        #1;
        chk("rst.y",          8'(y),          8'h0);
        chk("rst.sel_out",    8'(sel_out),    8'h0);
        chk("rst.valid",      8'(valid),      8'h0);
        chk("rst.sweep_done", 8'(sweep_done), 8'h0);
        chk("rst.state",      8'(fsm_state),  8'h0);
        chk("rst.b.valid",    8'(valid_b),    8'h0);
        reset_b = 1'b1;

        // Manual: step sel_in 0..3 on both DUTs
        for (int s = 0; s < 4; s++) begin
            sel_in   = 2'(s);
            sel_in_b = 2'(s);
            push(1'b1, 1'b0, 2'(s), CA + 4'(s));
            if (s < 3) push_b(1'b1, 2'(s), CA + 4'(s));
            else       push_b(1'b0, 2'd3, 4'h0);   // sel_in 3 out of range for N_CH=3
            tick("manual");
        end
        sel_in = 2'd0;
        push(1'b1, 1'b0, 2'd0, CA);
        tick("manual0");

        // Auto-scan, mask 1011: channel 2 skipped, wrap to 0
        mode    = 2'b01;
        en_mask = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, scan_seq[i], scan_y[i]);
            tick("auto");
        end

        // Empty mask: valid drops, y and sel_out hold while d changes
        en_mask = 4'b0000;
        d       = 16'h1234;
        push(1'b0, 1'b0, 2'd0, CA);
        tick("auto.nomask");
        push(1'b0, 1'b0, 2'd0, CA);
        tick("auto.nomask");

        // Back onto channel 1 with the dwell half spent, then hold
        d       = 16'hDCBA;
        en_mask = 4'b1011;
        push(1'b1, 1'b0, 2'd0, CA);
        tick("auto.pre");
        push(1'b1, 1'b0, 2'd1, CB);
        tick("auto.pre");
        push(1'b1, 1'b0, 2'd1, CB);
        tick("auto.pre");

        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom());
            push(1'b1, 1'b0, 2'd1, CB);
            tick("hold");
        end

        // Return to auto-scan: dwell restarts, channel 1 shown for two cycles
        mode = 2'b01;
        d    = 16'hDCBA;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("auto.reentry");
        push(1'b1, 1'b0, 2'd1, CB);
        tick("auto.reentry");
        push(1'b1, 1'b0, 2'd3, CD);
        tick("auto.reentry");

        // Single-sweep, mask 0110
        mode    = 2'b11;
        en_mask = 4'b0110;
        push(1'b1, 1'b0, 2'd3, CD);
        tick("sweep.idle");
        start = 1'b1;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("sweep.s1");
        start = 1'b0;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("sweep.s2");
        start = 1'b1;                          // ignored while sweeping
        push(1'b1, 1'b0, 2'd2, CC);
        tick("sweep.s3");
        start = 1'b0;
        push(1'b1, 1'b0, 2'd2, CC);
        tick("sweep.s4");
        d = 16'h5678;                          // y must keep C from here on
        push(1'b1, 1'b1, 2'd2, CC);
        tick("sweep.done");
        chk("sweep.done.state", 8'(fsm_state), 8'h2);
        push(1'b1, 1'b0, 2'd2, CC);
        tick("sweep.after");
        push(1'b1, 1'b0, 2'd2, CC);
        tick("sweep.after");
        chk("sweep.after.state", 8'(fsm_state), 8'h0);

        // Abort a sweep by switching to auto-scan: no sweep_done, scan continues
        d     = 16'hDCBA;
        start = 1'b1;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("abort.s1");
        start = 1'b0;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("abort.s2");
        mode = 2'b01;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("abort.a1");
        push(1'b1, 1'b0, 2'd1, CB);
        tick("abort.a2");
        push(1'b1, 1'b0, 2'd2, CC);
        tick("abort.a3");
        push(1'b1, 1'b0, 2'd2, CC);
        tick("abort.a4");
        push(1'b1, 1'b0, 2'd1, CB);
        tick("abort.wrap");

        // Start with an empty mask: immediate single sweep_done, valid low
        mode    = 2'b11;
        en_mask = 4'b0000;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("zmask.idle");
        start = 1'b1;
        push(1'b0, 1'b1, 2'd1, CB);
        tick("zmask.start");
        start = 1'b0;
        push(1'b0, 1'b0, 2'd1, CB);
        tick("zmask.after");

        // Asynchronous reset in the middle of a sweep
        en_mask = 4'b0110;
        start   = 1'b1;
        push(1'b1, 1'b0, 2'd1, CB);
        tick("rst2.s1");
        start = 1'b0;
        #2;
        reset_b = 1'b0;
        #1;
        chk("rst2.y",          8'(y),          8'h0);
        chk("rst2.sel_out",    8'(sel_out),    8'h0);
        chk("rst2.valid",      8'(valid),      8'h0);
        chk("rst2.sweep_done", 8'(sweep_done), 8'h0);
        chk("rst2.state",      8'(fsm_state),  8'h0);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 2'd0, 4'h0);
            tick("rst2.held");
        end
        reset_b = 1'b1;
        mode    = 2'b00;
        push(1'b1, 1'b0, 2'd0, CA);
        tick("rst2.release");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb.drain: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
